forward_hazard_unit: RTL and testbench
======================================

// Module: forward_hazard_unit
// PURPOSE
//  Parametrised operand-forwarding and load-use hazard unit for the pipelined core.
//  Gives each of NSRC EX-stage source operands a bypass select.
//  Adds a registered last-writeback bypass and a multi-cycle load-use stall FSM.
//  Sits between ID/EX, EX/MEM and MEM/WB pipeline registers; drives the EX operand muxes and the ID stall/bubble.
// PARAMETERS
//  WIDTH     4   register-address width
//  NSRC      2   source operands per instruction (1..4)
//  LOAD_LAT  1   cycles a load result trails EX; load-use stall length (1..7)
//  CNT_W     16  width of stall-cycle statistics counter
// PORTS
//  CLK          in   1            clock, rising edge
//  RST_N        in   1            async reset, active low
//  EX_SRC       in   NSRC*WIDTH   source addresses of instr in EX; operand i = [i*WIDTH +: WIDTH]
//  ID_VALID     in   1            valid instruction in ID
//  ID_SRC       in   NSRC*WIDTH   source addresses of instr in ID
//  ID_EX_DST    in   WIDTH        destination of instr in EX
//  ID_EX_WB     in   1            instr in EX writes a register
//  ID_EX_LOAD   in   1            instr in EX is a load
//  EXE_MEM_DST  in   WIDTH        destination in EX/MEM
//  EXE_MEM_WB   in   1            EX/MEM writes back
//  MEM_WB_DST   in   WIDTH        destination in MEM/WB
//  MEM_WB_WB    in   1            MEM/WB writes back
//  FM           out  NSRC*2       per-operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 last-WB reg
//  STALL        out  1            hold PC and IF/ID
//  BUBBLE       out  1            zero ID/EX control this cycle (== STALL)
//  STALL_CNT    out  CNT_W        saturating count of stalled cycles
// BEHAVIOUR
//  Register 0 is hardwired: address 0 never matches any source.
//  FM (combinational), per operand i, priority high->low:
//   - EXE_MEM_WB & EXE_MEM_DST==src -> 01
//   - MEM_WB_WB & MEM_WB_DST==src -> 10
//   - WBL_V & WBL_DST==src -> 11
//   - else 00
//  Last-WB register, each clock:
//   - WBL_V <= MEM_WB_WB & (MEM_WB_DST!=0)
//   - WBL_DST <= MEM_WB_DST
//   - Covers regfile with no write-through; holds one entry only.
//  Hazard: HZ = ID_VALID & ID_EX_LOAD & ID_EX_WB & ID_EX_DST!=0 & (any ID_SRC operand == ID_EX_DST).
//  FSM, states IDLE and HOLD; 3-bit down-counter CNT:
//   - IDLE: STALL = HZ. On HZ with LOAD_LAT>1 -> HOLD, CNT <= LOAD_LAT-1. On HZ with LOAD_LAT==1 stay IDLE.
//   - HOLD: STALL = 1; ID_EX inputs ignored (bubbles). CNT <= CNT-1. When CNT==1 -> IDLE.
//   - Total stall per hazard is exactly LOAD_LAT cycles, including the detection cycle.
//   - A new HZ in the first IDLE cycle after HOLD starts a fresh stall; there is no idle gap.
//  STALL_CNT increments every cycle STALL=1 and saturates at all-ones.
//  Simultaneous events: a forwarding match and HZ in the same cycle are independent; FM is valid while stalled.
//  Reset (any time, including mid-HOLD): state IDLE, CNT 0, WBL_V 0, WBL_DST 0, STALL_CNT 0.
//   - Outputs during reset: STALL=0 and BUBBLE=0 unless ID_VALID & HZ; FM per current inputs (WBL path off).
// TESTING
//  1 EX_SRC op0=3 with EXE_MEM_DST=3/WB=1 and MEM_WB_DST=3/WB=1 -> FM[1:0]=01 (EX/MEM wins).
//  2 Src=0 with EXE_MEM_DST=0/WB=1 -> FM=00. Src=5 with MEM_WB_DST=5, WB=0 -> 00.
//  3 MEM_WB_DST=6/WB=1 at cycle t, src=6 at t+1 with no other match -> FM=11 at t+1 only; 00 at t+2.
//  4 LOAD_LAT=1: load to r2 in EX, ID_SRC op1=2, ID_VALID=1 -> STALL=BUBBLE=1 one cycle, STALL_CNT=1.
//  5 LOAD_LAT=3: hazard -> STALL high 3 cycles; back-to-back second hazard -> 6 consecutive stall cycles.
//  6 RST_N low in 2nd HOLD cycle -> IDLE and STALL_CNT=0 immediately; no residual stall after release.

Source files
------------

// File: rtl/forward_hazard_unit.sv
// Operand-forwarding select and load-use stall control for the EX stage.
// One forwarding lane per source operand; shared last-writeback register and stall FSM.

module forward_hazard_lane #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] ex_src,
  input  logic [WIDTH-1:0] id_src,
  input  logic [WIDTH-1:0] em_dst,
  input  logic             em_wb,
  input  logic [WIDTH-1:0] mw_dst,
  input  logic             mw_wb,
  input  logic             wbl_v,
  input  logic [WIDTH-1:0] wbl_dst,
  input  logic [WIDTH-1:0] ld_dst,
  output logic [1:0]       sel,
  output logic             ld_hit
);
  // r0 is hardwired, so a zero source never takes a bypass
  always_comb begin
    sel = 2'b00;
    if (ex_src != '0) begin
      if (em_wb && (em_dst == ex_src))        sel = 2'b01;
      else if (mw_wb && (mw_dst == ex_src))   sel = 2'b10;
      else if (wbl_v && (wbl_dst == ex_src))  sel = 2'b11;
    end
  end

  assign ld_hit = (id_src == ld_dst);
endmodule

module forward_hazard_unit #(
  parameter int WIDTH    = 4,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NSRC*WIDTH-1:0] EX_SRC,
  input  logic                  ID_VALID,
  input  logic [NSRC*WIDTH-1:0] ID_SRC,
  input  logic [WIDTH-1:0]      ID_EX_DST,
  input  logic                  ID_EX_WB,
  input  logic                  ID_EX_LOAD,
  input  logic [WIDTH-1:0]      EXE_MEM_DST,
  input  logic                  EXE_MEM_WB,
  input  logic [WIDTH-1:0]      MEM_WB_DST,
  input  logic                  MEM_WB_WB,
  output logic [NSRC*2-1:0]     FM,
  output logic                  STALL,
  output logic                  BUBBLE,
  output logic [CNT_W-1:0]      STALL_CNT
);
  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);

  logic [NSRC-1:0][WIDTH-1:0] ex_src_a, id_src_a;
  logic [NSRC-1:0][1:0]       fm_a;
  logic [NSRC-1:0]            ld_hit;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             wbl_v_q, wbl_v_d;
  logic [WIDTH-1:0] wbl_dst_q, wbl_dst_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hz, stall;

  assign ex_src_a = EX_SRC;
  assign id_src_a = ID_SRC;

  for (genvar i = 0; i < NSRC; i++) begin : g_lane
    forward_hazard_lane #(.WIDTH(WIDTH)) u_lane (
      .ex_src  (ex_src_a[i]),
      .id_src  (id_src_a[i]),
      .em_dst  (EXE_MEM_DST),
      .em_wb   (EXE_MEM_WB),
      .mw_dst  (MEM_WB_DST),
      .mw_wb   (MEM_WB_WB),
      .wbl_v   (wbl_v_q),
      .wbl_dst (wbl_dst_q),
      .ld_dst  (ID_EX_DST),
      .sel     (fm_a[i]),
      .ld_hit  (ld_hit[i])
    );
  end

  assign hz = ID_VALID & ID_EX_LOAD & ID_EX_WB & (ID_EX_DST != '0) & (|ld_hit);

  // Last-WB entry covers the regfile's missing write-through for one cycle
  always_comb begin
    wbl_v_d   = MEM_WB_WB & (MEM_WB_DST != '0);
    wbl_dst_d = MEM_WB_DST;
  end

  // Detection cycle stalls from IDLE; HOLD supplies the remaining LOAD_LAT-1 cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = hz;
        if (hz && (LOAD_LAT > 1)) begin
          state_d = HOLD;
          cnt_d   = CNT_INIT;
        end
      end
      HOLD: begin
        stall = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wbl_v_q     <= 1'b0;
      wbl_dst_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wbl_v_q     <= wbl_v_d;
      wbl_dst_q   <= wbl_dst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FM        = fm_a;
  assign STALL     = stall;
  assign BUBBLE    = stall;
  assign STALL_CNT = stall_cnt_q;
endmodule

// File: tb/tb_forward_hazard_unit.sv
// Scoreboard bench: two instances (LOAD_LAT=3 / 16-bit counter, LOAD_LAT=1 / 4-bit counter)
// share stimulus; a cycle-indexed reference model predicts every output.

module tb_forward_hazard_unit;
  localparam int W = 4;
  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N*W-1:0] ex_src, id_src;
  logic           id_valid;
  logic [W-1:0]   ex_dst, em_dst, mw_dst;
  logic           ex_wb, ex_ld, em_wb, mw_wb;

  logic [N*2-1:0] fm3, fm1;
  logic           st3, bb3, st1, bb1;
  logic [15:0]    sc3;
  logic [3:0]     sc1;

  forward_hazard_unit #(.WIDTH(W), .NSRC(N), .LOAD_LAT(3), .CNT_W(16)) dut3 (
    .CLK(clk), .RST_N(rst_n), .EX_SRC(ex_src), .ID_VALID(id_valid), .ID_SRC(id_src),
    .ID_EX_DST(ex_dst), .ID_EX_WB(ex_wb), .ID_EX_LOAD(ex_ld),
    .EXE_MEM_DST(em_dst), .EXE_MEM_WB(em_wb), .MEM_WB_DST(mw_dst), .MEM_WB_WB(mw_wb),
    .FM(fm3), .STALL(st3), .BUBBLE(bb3), .STALL_CNT(sc3));

  forward_hazard_unit #(.WIDTH(W), .NSRC(N), .LOAD_LAT(1), .CNT_W(4)) dut1 (
    .CLK(clk), .RST_N(rst_n), .EX_SRC(ex_src), .ID_VALID(id_valid), .ID_SRC(id_src),
    .ID_EX_DST(ex_dst), .ID_EX_WB(ex_wb), .ID_EX_LOAD(ex_ld),
    .EXE_MEM_DST(em_dst), .EXE_MEM_WB(em_wb), .MEM_WB_DST(mw_dst), .MEM_WB_WB(mw_wb),
    .FM(fm1), .STALL(st1), .BUBBLE(bb1), .STALL_CNT(sc1));

  typedef struct {
    logic [N*2-1:0] fm;
    logic           st3;
    logic           st1;
    logic [15:0]    sc3;
    logic [3:0]     sc1;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state: last writeback seen, stall window end per latency, stall tallies
  logic        m_wv = 1'b0;
  logic [W-1:0] m_wd = '0;
  int          cyc_n = 0;
  int          end3 = 0, end1 = 0;
  int          cnt3 = 0, cnt1 = 0;

  function automatic logic [1:0] fwd(input logic [W-1:0] src);
    if (src == 0)                      return 2'd0;
    if (em_wb && em_dst == src)        return 2'd1;
    if (mw_wb && mw_dst == src)        return 2'd2;
    if (m_wv && m_wd == src)           return 2'd3;
    return 2'd0;
  endfunction

  task automatic cyc(input logic r, input logic [N*W-1:0] exs, input logic idv,
                     input logic [N*W-1:0] ids, input logic [W-1:0] exd, input logic exwb,
                     input logic exld, input logic [W-1:0] emd, input logic emwb,
                     input logic [W-1:0] mwd, input logic mwwb);
    exp_t e;
    logic hz, in3, in1;
    @(negedge clk);
    rst_n = r; ex_src = exs; id_valid = idv; id_src = ids; ex_dst = exd;
    ex_wb = exwb; ex_ld = exld; em_dst = emd; em_wb = emwb; mw_dst = mwd; mw_wb = mwwb;
    if (!r) begin
      m_wv = 1'b0; m_wd = '0; end3 = 0; end1 = 0; cnt3 = 0; cnt1 = 0;
    end
    for (int i = 0; i < N; i++) e.fm[i*2 +: 2] = fwd(ex_src[i*W +: W]);
    hz = 1'b0;
    for (int i = 0; i < N; i++)
      if (id_src[i*W +: W] == ex_dst) hz = 1'b1;
    hz = hz && id_valid && ex_ld && ex_wb && (ex_dst != 0);
    in3 = (cyc_n < end3);
    in1 = (cyc_n < end1);
    e.st3 = in3 || hz;
    e.st1 = in1 || hz;
    e.sc3 = 16'(cnt3);
    e.sc1 = 4'(cnt1);
    q.push_back(e);
    if (r) begin
      if (!in3 && hz) end3 = cyc_n + 3;
      if (!in1 && hz) end1 = cyc_n + 1;
      if (e.st3 && cnt3 < 65535) cnt3++;
      if (e.st1 && cnt1 < 15) cnt1++;
      m_wv = mw_wb && (mw_dst != 0);
      m_wd = mw_dst;
    end
    cyc_n++;
  endtask

  task automatic idle(input logic r);
    cyc(r, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // load to r2 in EX, ID operand 1 reads r2
  task automatic haz();
    cyc(1'b1, '0, 1'b1, 8'h20, 4'd2, 1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle_time=%0t got=%0h exp=%0h", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fm_lat3",     32'(fm3), 32'(e.fm));
        chk("fm_lat1",     32'(fm1), 32'(e.fm));
        chk("stall_lat3",  32'(st3), 32'(e.st3));
        chk("bubble_lat3", 32'(bb3), 32'(e.st3));
        chk("stall_lat1",  32'(st1), 32'(e.st1));
        chk("bubble_lat1", 32'(bb1), 32'(e.st1));
        chk("cnt_lat3",    32'(sc3), 32'(e.sc3));
        chk("cnt_lat1",    32'(sc1), 32'(e.sc1));
      end
    end
  end

  initial begin
    rst_n = 1'b0; ex_src = '0; id_valid = 1'b0; id_src = '0; ex_dst = '0;
    ex_wb = 1'b0; ex_ld = 1'b0; em_dst = '0; em_wb = 1'b0; mw_dst = '0; mw_wb = 1'b0;
    idle(1'b0);
    idle(1'b0);
    // hazard visible combinationally while in reset, counters stay zero
    cyc(1'b0, '0, 1'b1, 8'h20, 4'd2, 1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
    idle(1'b1);
    // EX/MEM beats MEM/WB on op0
    cyc(1'b1, 8'h03, 1'b0, '0, '0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1);
    // r0 never forwards; MEM/WB without WB does not forward
    cyc(1'b1, 8'h50, 1'b0, '0, '0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0);
    // last-WB bypass lives exactly one cycle
    cyc(1'b1, '0,    1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 4'd6, 1'b1);
    cyc(1'b1, 8'h06, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    cyc(1'b1, 8'h06, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    // single hazard
    haz();
    repeat (4) idle(1'b1);
    // hazard held 4 cycles: back-to-back stalls with no idle gap
    repeat (4) haz();
    repeat (4) idle(1'b1);
    // reset in the second HOLD cycle
    haz();
    idle(1'b1);
    idle(1'b0);
    repeat (4) idle(1'b1);
    // long hazard saturates the 4-bit counter
    repeat (20) haz();
    idle(1'b1);
    idle(1'b0);
    idle(1'b1);
    for (int k = 0; k < 300; k++) begin
      cyc($urandom_range(0, 49) != 0,
          {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))},
          $urandom_range(0, 3) != 0,
          {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))},
          4'($urandom_range(0, 5)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          4'($urandom_range(0, 5)), $urandom_range(0, 1) == 1,
          4'($urandom_range(0, 5)), $urandom_range(0, 1) == 1);
    end
    idle(1'b1);
    @(negedge clk);
    #5;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
